// File: rtl/d_mem_responder.sv
// Data-memory responder: two byte banks behind an IDLE/WAIT/RESP handshake
// with programmable wait states and big-endian word layout.
module d_mem_responder #(
  parameter int unsigned DEPTH_W     = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_mem_assert,
  input  logic        d_mem_cmd,
  input  logic [15:0] d_mem_addr,
  input  logic        d_mem_be0,
  input  logic        d_mem_be1,
  input  logic [15:0] d_mem_data_out,
  output logic [15:0] d_mem_data_in,
  output logic        d_mem_rdy,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;
  localparam int unsigned AW    = DEPTH_W + 1;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          capture, enter_resp, mem_we;

  logic [AW-1:0] addr_q;
  logic          cmd_q, be0_q, be1_q;
  logic [15:0]   wdata_q;

  logic [AW-1:0]      eff_addr;
  logic               eff_cmd, eff_word;
  logic [DEPTH_W-1:0] rd_idx;
  logic [15:0]        load_data;

  logic [7:0] mem_even [DEPTH];
  logic [7:0] mem_odd  [DEPTH];

  // Address bits above the storage index alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^d_mem_addr[15:AW];

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (d_mem_assert) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!d_mem_assert) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        mem_we    = cmd_q;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Zero-wait requests are served straight from the live inputs.
  always_comb begin
    if (state == S_IDLE) begin
      eff_addr = d_mem_addr[AW-1:0];
      eff_cmd  = d_mem_cmd;
      eff_word = d_mem_be0 & d_mem_be1;
    end else begin
      eff_addr = addr_q;
      eff_cmd  = cmd_q;
      eff_word = be0_q & be1_q;
    end
    rd_idx = eff_addr[AW-1:1];
    if (eff_word) begin
      load_data = {mem_even[rd_idx], mem_odd[rd_idx]};
    end else if (eff_addr[0]) begin
      load_data = {8'h00, mem_odd[rd_idx]};
    end else begin
      load_data = {8'h00, mem_even[rd_idx]};
    end
  end

  // State, registered outputs and request capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      d_mem_rdy     <= 1'b0;
      d_mem_data_in <= 16'h0000;
      busy          <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      d_mem_rdy <= enter_resp;
      busy      <= (state_nxt != S_IDLE);
      if (enter_resp && !eff_cmd) begin
        d_mem_data_in <= load_data;
      end
      if (capture) begin
        addr_q  <= d_mem_addr[AW-1:0];
        cmd_q   <= d_mem_cmd;
        be0_q   <= d_mem_be0;
        be1_q   <= d_mem_be1;
        wdata_q <= d_mem_data_out;
      end
    end
  end

  // Stores commit on the edge leaving RESP unless reset lands on that edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      if (be0_q && be1_q) begin
        mem_even[addr_q[AW-1:1]] <= wdata_q[15:8];
        mem_odd[addr_q[AW-1:1]]  <= wdata_q[7:0];
      end else if (addr_q[0]) begin
        mem_odd[addr_q[AW-1:1]]  <= wdata_q[7:0];
      end else begin
        mem_even[addr_q[AW-1:1]] <= wdata_q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_d_mem_responder.sv
// Bench for d_mem_responder: a zero-wait and a three-wait instance, each
// checked by a scoreboard fed from a flat byte-array reference model.
module tb_d_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v  [2];
  logic        cmd_v  [2];
  logic [15:0] addr_v [2];
  logic        be0_v  [2];
  logic        be1_v  [2];
  logic [15:0] wd_v   [2];
  logic [15:0] din_v  [2];
  logic        rdy_v  [2];
  logic        bsy_v  [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl [2][2048];
  logic [15:0] last_ld [2];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] e0, e1;

  always #5 clk = ~clk;

  d_mem_responder #(.DEPTH_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .d_mem_assert(req_v[0]), .d_mem_cmd(cmd_v[0]),
    .d_mem_addr(addr_v[0]), .d_mem_be0(be0_v[0]), .d_mem_be1(be1_v[0]),
    .d_mem_data_out(wd_v[0]), .d_mem_data_in(din_v[0]), .d_mem_rdy(rdy_v[0]),
    .busy(bsy_v[0])
  );

  d_mem_responder #(.DEPTH_W(10), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .d_mem_assert(req_v[1]), .d_mem_cmd(cmd_v[1]),
    .d_mem_addr(addr_v[1]), .d_mem_be0(be0_v[1]), .d_mem_be1(be1_v[1]),
    .d_mem_data_out(wd_v[1]), .d_mem_data_in(din_v[1]), .d_mem_rdy(rdy_v[1]),
    .busy(bsy_v[1])
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  task automatic push_exp(input int u, input logic [15:0] v);
    if (u == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  // Reference: flat 2 KiB byte space, even byte is the high half of a word.
  task automatic model_issue(input int u, input logic c, input logic [15:0] a,
                             input logic b0, input logic b1, input logic [15:0] w);
    int b;
    int ev;
    b  = int'(a) % 2048;
    ev = (b / 2) * 2;
    if (c) begin
      if (b0 && b1) begin
        mdl[u][ev]     = w[15:8];
        mdl[u][ev + 1] = w[7:0];
      end else begin
        mdl[u][b] = w[7:0];
      end
    end else begin
      last_ld[u] = (b0 && b1) ? {mdl[u][ev], mdl[u][ev + 1]} : {8'h00, mdl[u][b]};
    end
    push_exp(u, last_ld[u]);
  endtask

  task automatic drive(input int u, input logic c, input logic [15:0] a,
                       input logic b0, input logic b1, input logic [15:0] w);
    req_v[u]  = 1'b1;
    cmd_v[u]  = c;
    addr_v[u] = a;
    be0_v[u]  = b0;
    be1_v[u]  = b1;
    wd_v[u]   = w;
  endtask

  // One complete transaction; inputs are scrambled after sampling.
  task automatic txn(input int u, input logic c, input logic [15:0] a,
                     input logic b0, input logic b1, input logic [15:0] w);
    int lat;
    lat = lat_of(u);
    model_issue(u, c, a, b0, b1, w);
    @(negedge clk);
    drive(u, c, a, b0, b1, w);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n == 1) begin
        addr_v[u] = 16'($urandom);
        wd_v[u]   = 16'($urandom);
        cmd_v[u]  = 1'($urandom);
        be0_v[u]  = 1'($urandom);
        be1_v[u]  = 1'($urandom);
      end
      chk("busy_in_txn", 16'(bsy_v[u]), 16'd1);
      chk("rdy_timing", 16'(rdy_v[u]), 16'(n == lat));
    end
    req_v[u] = 1'b0;
    @(negedge clk);
    chk("busy_after", 16'(bsy_v[u]), 16'd0);
    chk("rdy_single_pulse", 16'(rdy_v[u]), 16'd0);
  endtask

  function automatic logic [15:0] win_addr(input int idx, input logic lsb);
    return (16'($urandom) & 16'hF800) | 16'(idx * 2) | 16'(lsb);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rdy_v[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0_unexpected_rdy actual=1 required=0");
      end else begin
        e0 = exp_q0.pop_front();
        chk("sb0_data", din_v[0], e0);
      end
    end
    if (rdy_v[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_unexpected_rdy actual=1 required=0");
      end else begin
        e1 = exp_q1.pop_front();
        chk("sb1_data", din_v[1], e1);
      end
    end
  end

  initial begin
    logic [15:0] a;
    int p;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_v[u] = 1'b0; cmd_v[u] = 1'b0; addr_v[u] = 16'h0;
      be0_v[u] = 1'b0; be1_v[u] = 1'b0; wd_v[u] = 16'h0;
      last_ld[u] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_rdy", 16'(rdy_v[u]), 16'd0);
      chk("reset_busy", 16'(bsy_v[u]), 16'd0);
      chk("reset_data_in", din_v[u], 16'h0000);
    end
    rst = 1'b0;

    // Worked examples on the zero-wait instance
    txn(0, 1'b1, 16'h00A0, 1'b1, 1'b1, 16'hC000);
    txn(0, 1'b0, 16'h00A0, 1'b1, 1'b1, 16'h0000);
    chk("ex_word_load", din_v[0], 16'hC000);
    txn(0, 1'b1, 16'h00A2, 1'b1, 1'b1, 16'hB000);
    txn(0, 1'b1, 16'h00A3, 1'b0, 1'b1, 16'h775A);
    chk("store_keeps_data_in", din_v[0], 16'hC000);
    txn(0, 1'b0, 16'h00A2, 1'b1, 1'b1, 16'h0000);
    chk("ex_merged_word", din_v[0], 16'hB05A);
    txn(0, 1'b0, 16'h00A2, 1'b1, 1'b0, 16'h0000);
    chk("ex_byte_load", din_v[0], 16'h00B0);

    // Fill a 32-word window on both instances through aliased addresses
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 32; i++)
        txn(u, 1'b1, win_addr(i, 1'b0), 1'b1, 1'b1, 16'($urandom));

    // Wrap-around, then back-to-back loads with the request held high
    txn(0, 1'b1, 16'h0800, 1'b1, 1'b1, 16'h1234);
    repeat (3) model_issue(0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
    @(negedge clk);
    drive(0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      chk("b2b_rdy", 16'(rdy_v[0]), 16'(n % 2 == 1));
      if (n == 5) req_v[0] = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end_rdy", 16'(rdy_v[0]), 16'd0);
    chk("wrap_load", din_v[0], 16'h1234);

    // Reset on the edge leaving RESP of a store
    push_exp(0, last_ld[0]);
    @(negedge clk);
    drive(0, 1'b1, 16'h0010, 1'b1, 1'b1, 16'hDEAD);
    @(negedge clk);
    chk("rst_resp_rdy", 16'(rdy_v[0]), 16'd1);
    rst = 1'b1;
    req_v[0] = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 16'(rdy_v[0]), 16'd0);
    chk("rst_busy", 16'(bsy_v[0]), 16'd0);
    chk("rst_data_in", din_v[0], 16'h0000);
    rst = 1'b0;
    last_ld[0] = 16'h0000;
    repeat (2) begin
      @(negedge clk);
      chk("rst_rdy_stays", 16'(rdy_v[0]), 16'd0);
    end
    txn(0, 1'b0, 16'h0010, 1'b1, 1'b1, 16'h0000);

    // Wait-state instance: plain load, then a store aborted mid-WAIT
    txn(1, 1'b0, 16'h0004, 1'b1, 1'b1, 16'h0000);
    @(negedge clk);
    drive(1, 1'b1, 16'h0020, 1'b1, 1'b1, 16'hBEEF);
    @(negedge clk);
    @(negedge clk);
    req_v[1] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_rdy", 16'(rdy_v[1]), 16'd0);
    end
    chk("abort_busy", 16'(bsy_v[1]), 16'd0);
    txn(1, 1'b0, 16'h0020, 1'b1, 1'b1, 16'h0000);

    // Randomized mix of word/byte loads/stores inside the window
    for (int u = 0; u < 2; u++) begin
      repeat (120) begin
        p = int'($urandom_range(3, 0));
        a = win_addr(int'($urandom_range(31, 0)), 1'($urandom));
        txn(u, 1'($urandom), a, p[0], p[1], 16'($urandom));
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 16'(exp_q0.size() + exp_q1.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
